// File: rtl/bin2bcd_seq_pkg.sv
// Shared calculator constants for the binary-to-BCD converter: digit width,
// FSM state encodings, the all-nines digit and the decimal max-value helper.
package bin2bcd_seq_pkg;

  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_NINE = 4'h9;

  // FSM encodings kept as plain vectors so older tools can use them too
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Largest value that fits in 'digits' decimal digits: 10^digits - 1
  function automatic int unsigned max_val(input int digits);
    int unsigned m;
    m = 1;
    for (int i = 0; i < digits; i++) m = m * 10;
    return m - 1;
  endfunction

  localparam int DEF_DIGITS = 4;
  localparam int unsigned DEF_MAX = max_val(DEF_DIGITS);

endpackage

// File: rtl/bin2bcd_seq_if.sv
// Handshake/data bundle between the calculator control FSM (master) and the
// converter (slave). The blank vector exists only with LEADING_ZERO_BLANK_EN.
interface bin2bcd_seq_if #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
);
  logic                  start;
  logic [BIN_W-1:0]      bin_in;
  logic                  busy;
  logic                  done;
  logic [4*DIGITS-1:0]   bcd_out;
  logic                  ovf;
`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0]     blank;
`endif

  modport master (
    output start, bin_in,
`ifdef LEADING_ZERO_BLANK_EN
    input  blank,
`endif
    input  busy, done, bcd_out, ovf
  );

  modport slave (
    input  start, bin_in,
`ifdef LEADING_ZERO_BLANK_EN
    output blank,
`endif
    output busy, done, bcd_out, ovf
  );
endinterface

// File: rtl/bin2bcd_seq_add3.sv
// Double-dabble correction cell: a digit of 5 or more gets +3 so that the
// following left shift carries correctly into the next decimal digit.
module bcd_add3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one result per start.
// Optional feature macro: LEADING_ZERO_BLANK_EN adds the registered blank
// vector marking leading-zero digits.
module bin2bcd_seq
  import bin2bcd_seq_pkg::*;
#(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic           clk,
  input  logic           rst,
  bin2bcd_seq_if.slave   bus
);

  // Scratch holds one extra bit above the digits so a carry out of the top
  // digit during the steps is never dropped.
  localparam int SW = DIGIT_W * DIGITS + 1;
  localparam int BW = DIGIT_W * DIGITS;
  localparam int CW = $clog2(BIN_W + 1);
  localparam int unsigned MAX_V = max_val(DIGITS);

  logic [1:0]        state;
  logic [CW-1:0]     cnt;
  logic [BIN_W-1:0]  shreg;
  logic [SW-1:0]     scratch;
  logic [SW-1:0]     adj;
  logic [SW-1:0]     nxt_scratch;
  logic              ovf_pend;
  logic              last_step;

  logic              busy_q;
  logic              done_q;
  logic              ovf_q;
  logic [BW-1:0]     bcd_q;
  logic [BW-1:0]     bcd_nxt;

  // One add-3 cell per digit; the carry bit passes straight through
  for (genvar g = 0; g < DIGITS; g++) begin : g_add3
    bcd_add3 u_add3 (
      .d(scratch[g*DIGIT_W +: DIGIT_W]),
      .q(adj[g*DIGIT_W +: DIGIT_W])
    );
  end
  assign adj[SW-1] = scratch[SW-1];

  // Shift the corrected scratch left, pulling in the next binary MSB
  assign nxt_scratch = {adj[SW-2:0], shreg[BIN_W-1]};
  assign last_step   = (cnt == CW'(1));

  // Saturate to all nines when the operand was out of range at accept
  assign bcd_nxt = ovf_pend ? {DIGITS{BCD_NINE}} : nxt_scratch[BW-1:0];

`ifdef LEADING_ZERO_BLANK_EN
  logic [DIGITS-1:0] blank_q;
  logic [DIGITS-1:0] blank_nxt;
  logic              zrun;

  // Walk from the top digit down; a digit is blank while everything above
  // it (and itself) is zero. Units digit always shows, nothing blanks on ovf.
  always_comb begin
    blank_nxt = '0;
    zrun      = 1'b1;
    for (int i = DIGITS - 1; i > 0; i--) begin
      zrun         = zrun & (bcd_nxt[i*DIGIT_W +: DIGIT_W] == 4'd0);
      blank_nxt[i] = zrun & ~ovf_pend;
    end
  end

  assign bus.blank = blank_q;
`endif

  // Control FSM, step counter, shift registers and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      shreg    <= '0;
      scratch  <= '0;
      ovf_pend <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
      bcd_q    <= '0;
`ifdef LEADING_ZERO_BLANK_EN
      blank_q  <= '0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          done_q <= 1'b0;
          if (bus.start) begin
            shreg    <= bus.bin_in;
            scratch  <= '0;
            cnt      <= CW'(BIN_W);
            ovf_pend <= (32'(bus.bin_in) > MAX_V);
            busy_q   <= 1'b1;
            state    <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          scratch <= nxt_scratch;
          shreg   <= {shreg[BIN_W-2:0], 1'b0};
          cnt     <= cnt - CW'(1);
          if (last_step) begin
            state  <= ST_DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            ovf_q  <= ovf_pend;
            bcd_q  <= bcd_nxt;
`ifdef LEADING_ZERO_BLANK_EN
            blank_q <= blank_nxt;
`endif
          end
        end
        ST_DONE: begin
          // start is ignored here; the pulse lasts exactly one cycle
          done_q <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_q;
  assign bus.done    = done_q;
  assign bus.ovf     = ovf_q;
  assign bus.bcd_out = bcd_q;

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: arithmetic reference model compared
// every cycle, plus directed conversions with literal expectations.
module tb_bin2bcd_seq;
  localparam int BIN_W  = 14;
  localparam int DIGITS = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  bin2bcd_seq_if #(.BIN_W(BIN_W), .DIGITS(DIGITS)) bus ();

  bin2bcd_seq #(.BIN_W(BIN_W), .DIGITS(DIGITS)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Decimal digits by plain division, units in the low nibble
  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int d;
    r = '0;
    d = 1;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'((v / d) % 10);
      d = d * 10;
    end
    return r;
  endfunction

  function automatic logic [3:0] to_blank(input logic [15:0] b, input logic o);
    logic [3:0] r;
    r = '0;
    if (!o) begin
      if (b[15:4] == 12'h0) r[1] = 1'b1;
      if (b[15:8] == 8'h0)  r[2] = 1'b1;
      if (b[15:12] == 4'h0) r[3] = 1'b1;
    end
    return r;
  endfunction

  // Reference model: result appears BIN_W edges after an accepted start,
  // done holds one cycle, no new accept until the cycle after done.
  int          m_left = 0;
  int          m_val  = 0;
  logic        m_busy = 1'b0;
  logic        m_done = 1'b0;
  logic        m_ovf  = 1'b0;
  logic [15:0] m_bcd  = '0;
  logic        chk_en = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_left <= 0; m_busy <= 1'b0; m_done <= 1'b0; m_ovf <= 1'b0; m_bcd <= '0;
    end else begin
      m_done <= 1'b0;
      if (m_left == 0 && !m_done && bus.start) begin
        m_left <= BIN_W;
        m_val  <= int'(bus.bin_in);
        m_busy <= 1'b1;
      end else if (m_left > 0) begin
        m_left <= m_left - 1;
        if (m_left == 1) begin
          m_busy <= 1'b0;
          m_done <= 1'b1;
          m_ovf  <= (m_val > 9999);
          m_bcd  <= (m_val > 9999) ? 16'h9999 : to_bcd(m_val);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_busy", 32'(bus.busy), 32'(m_busy));
      chk("cyc_done", 32'(bus.done), 32'(m_done));
      chk("cyc_ovf",  32'(bus.ovf),  32'(m_ovf));
      chk("cyc_bcd",  32'(bus.bcd_out), 32'(m_bcd));
`ifdef LEADING_ZERO_BLANK_EN
      chk("cyc_blank", 32'(bus.blank), 32'(to_blank(m_bcd, m_ovf)));
`endif
    end
  end

  // Pulse start for one cycle, wait for done, check latency and result
  task automatic conv(input int v, input logic [15:0] exp_bcd, input logic exp_ovf,
                      input string nm);
    int lat;
    int bcyc;
    @(negedge clk);
    bus.start  = 1'b1;
    bus.bin_in = 14'(v);
    @(negedge clk);
    bus.start = 1'b0;
    lat  = 0;
    bcyc = 0;
    while (!bus.done && lat < 40) begin
      if (bus.busy) bcyc++;
      @(negedge clk);
      lat++;
    end
    chk({nm, "_lat"},  32'(lat), 32'd14);
    chk({nm, "_busy"}, 32'(bcyc), 32'd14);
    chk({nm, "_bcd"},  32'(bus.bcd_out), 32'(exp_bcd));
    chk({nm, "_ovf"},  32'(bus.ovf), 32'(exp_ovf));
  endtask

  initial begin
    int npulse;
    logic [15:0] cap;
    bus.start  = 1'b0;
    bus.bin_in = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_done", 32'(bus.done), 32'd0);
    chk("rst_bcd",  32'(bus.bcd_out), 32'd0);
    chk("rst_ovf",  32'(bus.ovf), 32'd0);
    rst    = 1'b0;
    chk_en = 1'b1;

    // Pin the model's arithmetic to hand-computed values
    chk("mdl_1234", 32'(to_bcd(1234)), 32'h1234);
    chk("mdl_90",   32'(to_bcd(90)),   32'h0090);

    conv(0,     16'h0000, 1'b0, "zero");
`ifdef LEADING_ZERO_BLANK_EN
    chk("blank_0", 32'(bus.blank), 32'b1110);
`endif
    conv(9999,  16'h9999, 1'b0, "max");
    conv(5000,  16'h5000, 1'b0, "b2b_a");
    conv(90,    16'h0090, 1'b0, "b2b_b");
    conv(10000, 16'h9999, 1'b1, "ovf");
    conv(42,    16'h0042, 1'b0, "after_ovf");
`ifdef LEADING_ZERO_BLANK_EN
    chk("blank_42", 32'(bus.blank), 32'b1100);
`endif
    conv(1000,  16'h1000, 1'b0, "k");
`ifdef LEADING_ZERO_BLANK_EN
    chk("blank_1000", 32'(bus.blank), 32'b0000);
`endif
    conv(16383, 16'h9999, 1'b1, "top");

    // start re-pulsed mid-conversion must be ignored
    @(negedge clk);
    bus.start = 1'b1; bus.bin_in = 14'd3333;
    @(negedge clk);
    bus.start = 1'b0; bus.bin_in = 14'd7777;
    repeat (4) @(negedge clk);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    npulse = 0;
    cap = '0;
    repeat (30) begin
      @(negedge clk);
      if (bus.done) begin npulse++; cap = bus.bcd_out; end
    end
    chk("ign_pulses", 32'(npulse), 32'd1);
    chk("ign_bcd",    32'(cap), 32'h3333);

    // reset sampled on SHIFT step 7 aborts the conversion
    @(negedge clk);
    bus.start = 1'b1; bus.bin_in = 14'd5555;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (6) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_busy", 32'(bus.busy), 32'd0);
    chk("abort_bcd",  32'(bus.bcd_out), 32'd0);
    chk("abort_done", 32'(bus.done), 32'd0);
    npulse = 0;
    repeat (20) begin
      @(negedge clk);
      if (bus.done) npulse++;
    end
    chk("abort_nodone", 32'(npulse), 32'd0);
    conv(1234, 16'h1234, 1'b0, "post_abort");

    // rst and start together: start dropped
    @(negedge clk);
    rst = 1'b1; bus.start = 1'b1; bus.bin_in = 14'd77;
    @(negedge clk);
    rst = 1'b0; bus.start = 1'b0;
    @(negedge clk);
    chk("rst_start_busy", 32'(bus.busy), 32'd0);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
